// File: rtl/alu_core.sv
// alu_core: 32-bit registered ALU for the execute stage.
// The result and flags are registered one clock after an in_valid edge.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sample aluctl/a/b on this edge
//   aluctl     operation select (AND, OR, ADD, SUB, EQL, NOR; others yield 0)
//   a, b       32-bit operands
//   out        registered result
//   zero       registered, set when out is all zeros
//   overflow   registered two's-complement overflow (ADD/SUB only)
//   out_valid  registered, high for the cycle holding a fresh result
module alu_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  aluctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        zero,
    output logic        overflow,
    output logic        out_valid
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpEql = 4'b0111;
    localparam logic [3:0] OpNor = 4'b1100;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] res_d;
    logic        ovf_d;

    // Carry-out is discarded; both are plain 32-bit wraps.
    assign sum  = a + b;
    assign diff = a + ~b + 32'd1;

    always_comb begin
        res_d = 32'd0;
        ovf_d = 1'b0;
        case (aluctl)
            OpAnd: res_d = a & b;
            OpOr:  res_d = a | b;
            OpAdd: begin
                res_d = sum;
                ovf_d = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OpSub: begin
                res_d = diff;
                ovf_d = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            OpEql: res_d = (a == b) ? 32'd1 : 32'd0;
            OpNor: res_d = ~(a | b);
            default: begin
                res_d = 32'd0;
                ovf_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 32'd0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Without in_valid the previous result and flags are held.
            if (in_valid) begin
                out      <= res_d;
                zero     <= (res_d == 32'd0);
                overflow <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  aluctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        zero;
    logic        overflow;
    logic        out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    alu_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .aluctl    (aluctl),
        .a         (a),
        .b         (b),
        .out       (out),
        .zero      (zero),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_out, input logic e_z,
                             input logic e_ov, input logic e_v);
        check({tag, ".out"}, out, e_out);
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, e_z});
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e_ov});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_v});
    endtask

    // Drive one operation for one edge; inputs stay asserted so calls are back-to-back.
    task automatic op_step(input string tag, input logic [3:0] op, input logic [31:0] va,
                           input logic [31:0] vb, input logic [31:0] e_out, input logic e_ov);
        in_valid = 1'b1;
        aluctl   = op;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        check_all(tag, e_out, (e_out == 32'd0), e_ov, 1'b1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        aluctl   = 4'd0;
        a        = 32'd0;
        b        = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'd0, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back stream of directed vectors.
        op_step("and",     4'b0000, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000, 1'b0);
        op_step("or",      4'b0001, 32'hA0F25221, 32'hA0F83621, 32'hA0FA7621, 1'b0);
        op_step("nor",     4'b1100, 32'h80F04021, 32'h80F04021, 32'h7F0FBFDE, 1'b0);
        op_step("add_ov1", 4'b0010, 32'h80F04021, 32'h80F02421, 32'h01E06442, 1'b1);
        op_step("add_ov2", 4'b0010, 32'hA0F25221, 32'hA0F83621, 32'h41EA8842, 1'b1);
        op_step("add",     4'b0010, 32'h00027024, 32'h22DA3709, 32'h22DCA72D, 1'b0);
        op_step("sub1",    4'b0110, 32'h80F04021, 32'h80F02421, 32'h00001C00, 1'b0);
        op_step("sub2",    4'b0110, 32'h00027024, 32'h22DA3709, 32'hDD28391B, 1'b0);
        op_step("sub_ov",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1);
        op_step("eql_t",   4'b0111, 32'h80F04021, 32'h80F04021, 32'h00000001, 1'b0);
        op_step("eql_f",   4'b0111, 32'hA0F25221, 32'hA0F83621, 32'h00000000, 1'b0);
        op_step("undef",   4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        op_step("add_ovx", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1);

        // Idle: result and flags held, out_valid drops.
        in_valid = 1'b0;
        a        = 32'h12345678;
        aluctl   = 4'b0000;
        @(posedge clk);
        #1;
        check_all("hold1", 32'h80000000, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_all("hold2", 32'h80000000, 1'b0, 1'b1, 1'b0);

        // Mid-stream reset takes effect between edges.
        op_step("pre_rst", 4'b0001, 32'h0000F000, 32'h00000001, 32'h0000F001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held", 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        op_step("post_rst", 4'b0110, 32'h00000010, 32'h00000003, 32'h0000000D, 1'b0);

        in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_core.md
# alu_core

32-bit registered arithmetic/logic unit for the datapath execute stage. It takes two 32-bit operands and a 4-bit operation code and produces a 32-bit result with `zero` and signed-`overflow` flags. Results are registered one clock after the operands are accepted. Control decode upstream supplies `aluctl`, and downstream stages consume `out`, `zero` and `overflow` when `out_valid` is high.

## Interface
- Parameters: none. Data width is fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operands and `aluctl` are sampled on this edge.
- `aluctl`  input  4  operation select.
- `a`  input  32  operand A.
- `b`  input  32  operand B.
- `out`  output  32  registered result.
- `zero`  output  1  registered; 1 when `out` is all zeros.
- `overflow`  output  1  registered two's-complement overflow flag.
- `out_valid`  output  1  registered; 1 when `out`, `zero` and `overflow` hold a fresh result.

## Operation
Opcodes:
- 4'b0000 AND: `out = a & b`.
- 4'b0001 OR: `out = a | b`.
- 4'b0010 ADD: `out = (a + b) mod 2^32`.
- 4'b0110 SUB: `out = (a - b) mod 2^32`, computed as a + ~b + 1.
- 4'b0111 EQL: `out = (a == b) ? 32'd1 : 32'd0`.
- 4'b1100 NOR: `out = ~(a | b)`.
- All other codes: `out = 0`, `overflow = 0`. No error signalling.

Flags:
- `zero = (out == 0)`, valid for every opcode, including undefined codes (`zero = 1`).
- `overflow` for ADD: `a[31] == b[31]` and `out[31] != a[31]`.
- `overflow` for SUB: `a[31] != b[31]` and `out[31] != a[31]`.
- `overflow` is 0 for every other opcode.
- Carry-out is discarded and not exported.
- Operands are treated as unsigned for EQL and as two's complement only for the overflow flag.

## Timing
- Reset (`rst_n` low, asynchronous): `out = 0`, `zero = 1`, `overflow = 0`, `out_valid = 0`. Reset takes effect immediately, regardless of `clk`. Release is synchronous to the next rising edge.
- Rising edge with `in_valid = 1`: result and flags of the sampled inputs are registered.
  - They appear on the outputs after that edge (latency 1 cycle).
  - `out_valid = 1` for that cycle.
- Rising edge with `in_valid = 0`: `out`, `zero` and `overflow` hold their previous values; `out_valid = 0`.
- Throughput is one operation per cycle. Back-to-back `in_valid` gives back-to-back results with no bubbles.
- There is no backpressure. Downstream must capture the result in the `out_valid` cycle.
- Reset asserted mid-stream discards any in-flight result. The first `in_valid` edge after release produces a normal result.
- Combinational path is from the input registers' sampling edge only. There is no combinational input-to-output path.

## Test plan
- Logic ops:
  - AND a=0x0F0F0F0F, b=0xF0F0F0F0 -> out=0, zero=1, overflow=0.
  - OR a=0xA0F25221, b=0xA0F83621 -> out=0xA0FA7621, zero=0.
  - NOR a=b=0x80F04021 -> out=0x7F0FBFDE.
- ADD:
  - a=0x80F04021, b=0x80F02421 -> out=0x01E06442, overflow=1.
  - a=0xA0F25221, b=0xA0F83621 -> out=0x41EA8842, overflow=1.
  - a=0x00027024, b=0x22DA3709 -> out=0x22DCA72D, overflow=0.
- SUB:
  - a=0x80F04021, b=0x80F02421 -> out=0x00001C00, overflow=0.
  - a=0x00027024, b=0x22DA3709 -> out=0xDD28391B, overflow=0.
  - a=0x80000000, b=1 -> out=0x7FFFFFFF, overflow=1.
- EQL:
  - a=b=0x80F04021 -> out=1, zero=0.
  - a=0xA0F25221, b=0xA0F83621 -> out=0, zero=1.
  - Undefined opcode 4'b0011 -> out=0, zero=1, overflow=0.
- Timing and handshake:
  - Reset mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.
  - Back-to-back `in_valid` -> one result per cycle, each at latency 1.
  - `in_valid` low -> outputs held, `out_valid = 0`.
